// File: rtl/rom_arb_pkg.sv
// Shared types and default SDRAM layout for the ROM read-port arbiter.
// Client IDs double as indices into the per-client request/grant vectors.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        CL_TILES = 2'd0,
        CL_SPR   = 2'd1,
        CL_M68K  = 2'd2,
        CL_THEME = 2'd3
    } client_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [24:0] DEF_TILES_BASE = 25'h0000000;
    localparam logic [24:0] DEF_SPR_BASE   = 25'h0100000;
    localparam logic [24:0] DEF_THEME_BASE = 25'h0300000;
    localparam logic [24:0] DEF_M68K_BASE  = 25'h0400000;

endpackage

// File: rtl/rom_arb_slot.sv
// One client slot: pending flag, latched request address and read-data holding register.
// A fresh request beats a same-cycle grant so the newer address is never dropped.
module rom_arb_slot #(
    parameter int AW = 18,
    parameter int DW = 32
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          req,
    input  logic [AW-1:0] req_addr,
    input  logic          grant,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    output logic          pend,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] dout,
    output logic          overwrite
);

    logic          pend_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] dout_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_reg <= 1'b0;
            addr_reg <= '0;
            dout_reg <= '0;
        end else begin
            if (req) begin
                pend_reg <= 1'b1;
                addr_reg <= req_addr;
            end else if (grant) begin
                pend_reg <= 1'b0;
            end
            if (load) begin
                dout_reg <= load_data;
            end
        end
    end

    // A pulse that lands while the grant is consuming pend is a new request, not a lost one.
    assign overwrite = req & pend_reg & ~grant;
    assign pend      = pend_reg;
    assign addr      = addr_reg;
    assign dout      = dout_reg;

endmodule

// File: rtl/rom_arbiter.sv
// Fixed-priority arbiter sharing one SDRAM read port among tiles, sprites, 68000 and theme ROMs.
// One transaction in flight; also generates the 68000 DTACK stretch and a sticky video overrun flag.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter logic [24:0] TILES_BASE = DEF_TILES_BASE,
    parameter logic [24:0] SPR_BASE   = DEF_SPR_BASE,
    parameter logic [24:0] THEME_BASE = DEF_THEME_BASE,
    parameter logic [24:0] M68K_BASE  = DEF_M68K_BASE
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        tiles_rom_req,
    input  logic [17:0] tiles_rom_addr,
    output logic [31:0] tiles_rom_dout,
    input  logic        spr_rom_req,
    input  logic [18:0] spr_rom_addr,
    output logic [31:0] spr_rom_dout,
    input  logic        theme_rom_req,
    input  logic [17:0] theme_rom_addr,
    output logic [31:0] theme_rom_dout,
    input  logic        m68k_rom_req,
    input  logic [17:0] m68k_rom_addr,
    output logic [15:0] m68k_rom_dout,
    output logic        sdram_dtack,
    output logic        mem_req,
    output logic [24:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_dout,
    output logic        overrun
);

    logic [3:0]  pend;
    logic [3:0]  grant;
    logic [3:0]  load;
    logic [3:0]  overwrite;

    logic [17:0] tiles_addr;
    logic [18:0] spr_addr;
    logic [17:0] theme_addr;
    logic [17:0] m68k_addr;
    logic [15:0] m68k_load_data;

    state_t      state_reg, state_next;
    client_t     client_reg, client_next;
    client_t     winner;
    logic        mem_req_reg, mem_req_next;
    logic [24:0] mem_addr_reg, mem_addr_next;
    logic        m68k_hi_reg, m68k_hi_next;
    logic        dtack_reg;
    logic        overrun_reg;
    logic [24:0] winner_addr;

    rom_arb_slot #(.AW(18), .DW(32)) u_tiles (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .req       (tiles_rom_req),
        .req_addr  (tiles_rom_addr),
        .grant     (grant[CL_TILES]),
        .load      (load[CL_TILES]),
        .load_data (mem_dout),
        .pend      (pend[CL_TILES]),
        .addr      (tiles_addr),
        .dout      (tiles_rom_dout),
        .overwrite (overwrite[CL_TILES])
    );

    rom_arb_slot #(.AW(19), .DW(32)) u_spr (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .req       (spr_rom_req),
        .req_addr  (spr_rom_addr),
        .grant     (grant[CL_SPR]),
        .load      (load[CL_SPR]),
        .load_data (mem_dout),
        .pend      (pend[CL_SPR]),
        .addr      (spr_addr),
        .dout      (spr_rom_dout),
        .overwrite (overwrite[CL_SPR])
    );

    rom_arb_slot #(.AW(18), .DW(16)) u_m68k (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .req       (m68k_rom_req),
        .req_addr  (m68k_rom_addr),
        .grant     (grant[CL_M68K]),
        .load      (load[CL_M68K]),
        .load_data (m68k_load_data),
        .pend      (pend[CL_M68K]),
        .addr      (m68k_addr),
        .dout      (m68k_rom_dout),
        .overwrite (overwrite[CL_M68K])
    );

    rom_arb_slot #(.AW(18), .DW(32)) u_theme (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .req       (theme_rom_req),
        .req_addr  (theme_rom_addr),
        .grant     (grant[CL_THEME]),
        .load      (load[CL_THEME]),
        .load_data (mem_dout),
        .pend      (pend[CL_THEME]),
        .addr      (theme_addr),
        .dout      (theme_rom_dout),
        .overwrite (overwrite[CL_THEME])
    );

    // The 68000 fetches 16-bit words out of a 32-bit SDRAM word; half chosen by the grant-time LSB.
    assign m68k_load_data = m68k_hi_reg ? mem_dout[31:16] : mem_dout[15:0];

    always_comb begin
        winner = CL_THEME;
        if (pend[CL_TILES]) begin
            winner = CL_TILES;
        end else if (pend[CL_SPR]) begin
            winner = CL_SPR;
        end else if (pend[CL_M68K]) begin
            winner = CL_M68K;
        end
    end

    always_comb begin
        winner_addr = THEME_BASE + {5'd0, theme_addr, 2'b00};
        case (winner)
            CL_TILES: winner_addr = TILES_BASE + {5'd0, tiles_addr, 2'b00};
            CL_SPR:   winner_addr = SPR_BASE + {4'd0, spr_addr, 2'b00};
            CL_M68K:  winner_addr = M68K_BASE + {6'd0, m68k_addr[17:1], 2'b00};
            default:  winner_addr = THEME_BASE + {5'd0, theme_addr, 2'b00};
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        client_next   = client_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;
        m68k_hi_next  = m68k_hi_reg;
        grant         = 4'b0000;
        load          = 4'b0000;
        case (state_reg)
            ST_IDLE: begin
                if (|pend) begin
                    grant[winner] = 1'b1;
                    client_next   = winner;
                    mem_addr_next = winner_addr;
                    mem_req_next  = 1'b1;
                    m68k_hi_next  = m68k_addr[0];
                    state_next    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    load[client_reg] = 1'b1;
                    mem_req_next     = 1'b0;
                    state_next       = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            client_reg   <= CL_TILES;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            m68k_hi_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            client_reg   <= client_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
            m68k_hi_reg  <= m68k_hi_next;
        end
    end

    // A new 68000 request outranks a same-cycle completion: that new cycle still needs its data.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dtack_reg   <= 1'b1;
            overrun_reg <= 1'b0;
        end else begin
            if (m68k_rom_req) begin
                dtack_reg <= 1'b0;
            end else if (load[CL_M68K]) begin
                dtack_reg <= 1'b1;
            end
            if (overwrite[CL_TILES] | overwrite[CL_SPR]) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign sdram_dtack = dtack_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a table of single-client reads plus hand-written
// sequences for priority, coincident request/ack, overwrite and mid-transaction reset.
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        tiles_rom_req, spr_rom_req, theme_rom_req, m68k_rom_req;
    logic [17:0] tiles_rom_addr, theme_rom_addr, m68k_rom_addr;
    logic [18:0] spr_rom_addr;
    logic [31:0] tiles_rom_dout, spr_rom_dout, theme_rom_dout;
    logic [15:0] m68k_rom_dout;
    logic        sdram_dtack, mem_req, mem_ack, overrun;
    logic [24:0] mem_addr;
    logic [31:0] mem_dout;

    int passed = 0;
    int total  = 0;

    rom_arbiter dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .tiles_rom_req  (tiles_rom_req),
        .tiles_rom_addr (tiles_rom_addr),
        .tiles_rom_dout (tiles_rom_dout),
        .spr_rom_req    (spr_rom_req),
        .spr_rom_addr   (spr_rom_addr),
        .spr_rom_dout   (spr_rom_dout),
        .theme_rom_req  (theme_rom_req),
        .theme_rom_addr (theme_rom_addr),
        .theme_rom_dout (theme_rom_dout),
        .m68k_rom_req   (m68k_rom_req),
        .m68k_rom_addr  (m68k_rom_addr),
        .m68k_rom_dout  (m68k_rom_dout),
        .sdram_dtack    (sdram_dtack),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_dout       (mem_dout),
        .overrun        (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0]  cl;
        logic [18:0] addr;
        logic [31:0] data;
        logic [24:0] exp_addr;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("ok   %s: %h", name, act);
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dout_of(input logic [1:0] cl);
        case (cl)
            2'd0:    return tiles_rom_dout;
            2'd1:    return spr_rom_dout;
            2'd2:    return {16'h0000, m68k_rom_dout};
            default: return theme_rom_dout;
        endcase
    endfunction

    task automatic set_req(input logic [1:0] cl, input logic [18:0] a, input logic on);
        case (cl)
            2'd0:    begin tiles_rom_req = on; tiles_rom_addr = a[17:0]; end
            2'd1:    begin spr_rom_req   = on; spr_rom_addr   = a;       end
            2'd2:    begin m68k_rom_req  = on; m68k_rom_addr  = a[17:0]; end
            default: begin theme_rom_req = on; theme_rom_addr = a[17:0]; end
        endcase
    endtask

    task automatic pulse(input logic [1:0] cl, input logic [18:0] a);
        set_req(cl, a, 1'b1);
        tick();
        set_req(cl, a, 1'b0);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'd0, mem_req}, 32'd1);
    endtask

    // Acts as the SDRAM controller for one read: ack after `delay` cycles with `data`.
    task automatic serve(input string name, input logic [24:0] exp_addr,
                         input logic [31:0] data, input int delay);
        wait_req({name, "_req"});
        check({name, "_addr"}, {7'd0, mem_addr}, {7'd0, exp_addr});
        repeat (delay) tick();
        check({name, "_addr_hold"}, {7'd0, mem_addr}, {7'd0, exp_addr});
        mem_ack  = 1'b1;
        mem_dout = data;
        tick();
        mem_ack  = 1'b0;
        mem_dout = 32'h0;
        check({name, "_req_drop"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 19'h00010, 32'hDEADBEEF, 25'h0000040, 32'hDEADBEEF};
        vecs[1] = '{2'd1, 19'h00005, 32'hCAFEF00D, 25'h0100014, 32'hCAFEF00D};
        vecs[2] = '{2'd3, 19'h3FFFF, 32'h11223344, 25'h03FFFFC, 32'h11223344};
        vecs[3] = '{2'd2, 19'h00003, 32'h1234ABCD, 25'h0400004, 32'h00001234};
        vecs[4] = '{2'd2, 19'h00002, 32'h1234ABCD, 25'h0400004, 32'h0000ABCD};
        vecs[5] = '{2'd1, 19'h7FFFF, 32'h0F0F0F0F, 25'h02FFFFC, 32'h0F0F0F0F};

        reset = 1'b1;
        tiles_rom_req = 0; spr_rom_req = 0; theme_rom_req = 0; m68k_rom_req = 0;
        tiles_rom_addr = 0; spr_rom_addr = 0; theme_rom_addr = 0; m68k_rom_addr = 0;
        mem_ack = 0; mem_dout = 0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", {7'd0, mem_addr}, 32'd0);
        check("rst_dtack", {31'd0, sdram_dtack}, 32'd1);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_tiles_dout", tiles_rom_dout, 32'd0);
        check("rst_m68k_dout", {16'd0, m68k_rom_dout}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            pulse(vecs[i].cl, vecs[i].addr);
            check($sformatf("v%0d_lat_n1", i), {31'd0, mem_req}, 32'd0);
            if (vecs[i].cl == 2'd2)
                check($sformatf("v%0d_dtack_low", i), {31'd0, sdram_dtack}, 32'd0);
            tick();
            check($sformatf("v%0d_lat_n2", i), {31'd0, mem_req}, 32'd1);
            serve($sformatf("v%0d", i), vecs[i].exp_addr, vecs[i].data, 5);
            check($sformatf("v%0d_dout", i), dout_of(vecs[i].cl), vecs[i].exp_dout);
            check($sformatf("v%0d_dtack_high", i), {31'd0, sdram_dtack}, 32'd1);
            tick();
        end

        // Simultaneous tiles/sprites/theme: served in priority order with one idle cycle between.
        set_req(2'd0, 19'h00001, 1'b1);
        set_req(2'd1, 19'h00002, 1'b1);
        set_req(2'd3, 19'h00003, 1'b1);
        tick();
        set_req(2'd0, 19'h0, 1'b0);
        set_req(2'd1, 19'h0, 1'b0);
        set_req(2'd3, 19'h0, 1'b0);
        tick();
        serve("pri_tiles", 25'h0000004, 32'hA0A0A0A0, 2);
        tick();
        check("pri_spr_gap", {31'd0, mem_req}, 32'd1);
        serve("pri_spr", 25'h0100008, 32'hB1B1B1B1, 2);
        tick();
        check("pri_theme_gap", {31'd0, mem_req}, 32'd1);
        serve("pri_theme", 25'h030000C, 32'hC2C2C2C2, 2);
        check("pri_tiles_dout", tiles_rom_dout, 32'hA0A0A0A0);
        check("pri_spr_dout", spr_rom_dout, 32'hB1B1B1B1);
        check("pri_theme_dout", theme_rom_dout, 32'hC2C2C2C2);
        check("pri_overrun", {31'd0, overrun}, 32'd0);
        tick();

        // Sprite request coinciding with the sprite ack: both the data and the new read survive.
        pulse(2'd1, 19'h00001);
        wait_req("coin_req");
        check("coin_addr", {7'd0, mem_addr}, 32'h0100004);
        tick();
        mem_ack = 1'b1;
        mem_dout = 32'h5A5A1234;
        set_req(2'd1, 19'h00002, 1'b1);
        tick();
        mem_ack = 1'b0;
        mem_dout = 32'h0;
        set_req(2'd1, 19'h0, 1'b0);
        check("coin_dout", spr_rom_dout, 32'h5A5A1234);
        check("coin_idle", {31'd0, mem_req}, 32'd0);
        tick();
        check("coin_reissue", {31'd0, mem_req}, 32'd1);
        serve("coin2", 25'h0100008, 32'h77778888, 1);
        check("coin2_dout", spr_rom_dout, 32'h77778888);
        check("coin_overrun", {31'd0, overrun}, 32'd0);
        tick();

        // Tiles overwritten while waiting behind a long sprite read: one read, sticky overrun.
        pulse(2'd1, 19'h00004);
        wait_req("ovr_spr_req");
        pulse(2'd0, 19'h00010);
        check("ovr_first", {31'd0, overrun}, 32'd0);
        pulse(2'd0, 19'h00020);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        serve("ovr_spr", 25'h0100010, 32'h13572468, 8);
        tick();
        check("ovr_tiles_gap", {31'd0, mem_req}, 32'd1);
        serve("ovr_tiles", 25'h0000080, 32'h0BADF00D, 2);
        check("ovr_tiles_dout", tiles_rom_dout, 32'h0BADF00D);
        repeat (4) tick();
        check("ovr_single_read", {31'd0, mem_req}, 32'd0);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset in the middle of a 68000 read, then a stale ack from the controller.
        pulse(2'd2, 19'h00005);
        wait_req("mrst_req");
        check("mrst_dtack_low", {31'd0, sdram_dtack}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("mrst_mem_addr", {7'd0, mem_addr}, 32'd0);
        check("mrst_dtack", {31'd0, sdram_dtack}, 32'd1);
        check("mrst_overrun", {31'd0, overrun}, 32'd0);
        check("mrst_tiles_dout", tiles_rom_dout, 32'd0);
        check("mrst_spr_dout", spr_rom_dout, 32'd0);
        check("mrst_theme_dout", theme_rom_dout, 32'd0);
        check("mrst_m68k_dout", {16'd0, m68k_rom_dout}, 32'd0);
        mem_ack = 1'b1;
        mem_dout = 32'hFFFFFFFF;
        tick();
        mem_ack = 1'b0;
        mem_dout = 32'h0;
        check("late_ack_m68k_dout", {16'd0, m68k_rom_dout}, 32'd0);
        check("late_ack_dtack", {31'd0, sdram_dtack}, 32'd1);
        repeat (3) tick();
        check("late_ack_no_req", {31'd0, mem_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the single SDRAM read port among the four ROM consumers of the TMNT/MIA core: tile planes, sprites, the theme-music sample ROM and the 68000 program ROM. It latches one-cycle request pulses, grants them by fixed priority, runs one read transaction at a time, and returns data to per-client holding registers. It also generates `sdram_dtack`, which stretches 68000 ROM cycles until their data is valid. It sits between the `tmnt` top level and the MiSTer SDRAM controller.

## Interface

Parameters:
- `TILES_BASE`, 25'h0000000: SDRAM byte base of tile ROM
- `SPR_BASE`, 25'h0100000: SDRAM byte base of sprite ROM
- `THEME_BASE`, 25'h0300000: SDRAM byte base of theme ROM
- `M68K_BASE`, 25'h0400000: SDRAM byte base of 68000 ROM

Ports:
- `clk_sys`  in  1  96 MHz system clock, the only clock
- `reset`  in  1  synchronous, active-high
- `tiles_rom_req`  in  1  one-cycle request pulse
- `tiles_rom_addr`  in  18  32-bit word address
- `tiles_rom_dout`  out  32  tile data holding register
- `spr_rom_req`  in  1  one-cycle request pulse
- `spr_rom_addr`  in  19  32-bit word address
- `spr_rom_dout`  out  32  sprite data holding register
- `theme_rom_req`  in  1  one-cycle request pulse
- `theme_rom_addr`  in  18  32-bit word address
- `theme_rom_dout`  out  32  theme data holding register
- `m68k_rom_req`  in  1  one-cycle request pulse
- `m68k_rom_addr`  in  18  16-bit word address
- `m68k_rom_dout`  out  16  68000 data holding register
- `sdram_dtack`  out  1  1 = 68000 ROM data ready; 0 = stall
- `mem_req`  out  1  read request, level, held until `mem_ack`
- `mem_addr`  out  25  byte address, 4-byte aligned
- `mem_ack`  in  1  one-cycle pulse, `mem_dout` valid in the same cycle
- `mem_dout`  in  32  read data
- `overrun`  out  1  sticky: a video request was lost

## Operation

- Each client has a `pend` bit and an address register. A request pulse sets `pend` and loads the address.
- A new pulse while `pend` is set overwrites the address; only one read is issued.
- If the client is tiles or sprites, that overwrite also sets `overrun`. `overrun` clears only on `reset`.
- Fixed priority: tiles > sprites > m68k > theme.
- FSM states:
  - IDLE: if any `pend` is set, select the winner, clear its `pend`, record its ID, drive `mem_addr`, set `mem_req`, go to BUSY.
  - BUSY: on `mem_ack`, write `mem_dout` to the recorded client's holding register, drop `mem_req`, go to IDLE.
- Address mapping:
  - tiles/sprites/theme: `mem_addr = BASE + {addr, 2'b00}`.
  - m68k: `mem_addr = M68K_BASE + {addr[17:1], 2'b00}`; `m68k_rom_dout = addr[0] ? mem_dout[31:16] : mem_dout[15:0]`, using the address latched at grant.
- Additions are 25-bit, and overflow wraps.
- `sdram_dtack` clears the cycle after an m68k request pulse. It sets in the same edge that loads `m68k_rom_dout`.
- Holding registers keep their value until that client's next completion.

## Timing

- Reset values: all `pend` = 0, FSM = IDLE, `mem_req` = 0, `mem_addr` = 0, every `*_dout` = 0, `sdram_dtack` = 1, `overrun` = 0.
- Request pulse at edge N: `pend` is visible at N+1, and `mem_req` rises at N+2 if the port is idle and the client wins.
- `mem_ack` at edge M: data is in the holding register at M+1, and FSM = IDLE at M+1. The next grant's `mem_req` rises at M+2, giving a minimum of 1 idle cycle between transactions.
- `mem_ack` in IDLE is ignored.
- A request pulse in the same cycle as that client's `mem_ack`: the data is delivered and `pend` is set, so both take effect.
- A request pulse in the same cycle its `pend` is being cleared by a grant: `pend` stays set and the new address is kept. This case does not set `overrun`.
- `mem_addr` is stable for the whole time `mem_req` is high.
- `reset` mid-transaction aborts the transaction and returns every output to its reset value. The SDRAM controller shares the same `reset`.

## Structure

- Package `rom_arb_pkg`:
  - client ID enum (`CL_TILES`, `CL_SPR`, `CL_M68K`, `CL_THEME`)
  - FSM state enum
  - default base address constants
- Sub-module `rom_arb_slot` holds the `pend` bit, the address register, the overwrite detect and the holding register. It is instantiated 4×, with parameterised address and data widths.
- The top level contains the priority encoder, FSM, address mux, `sdram_dtack` and `overrun`.

## Test plan

- Tiles pulse, addr 18'h00010; memory acks 5 cycles after `mem_req` with 32'hDEADBEEF -> `mem_addr` = 25'h0000040, `mem_req` rises at N+2, `tiles_rom_dout` = DEADBEEF at ack+1.
- Tiles, sprites and theme pulse in the same cycle -> grants in order tiles, sprites, theme, with each `mem_req` starting 1 cycle after the previous ack; `overrun` stays 0.
- m68k pulse, addr 18'h00003; `mem_dout` = 32'h1234ABCD -> `mem_addr` = M68K_BASE + 4, `sdram_dtack` is 0 from N+1 until ack, then 1 with `m68k_rom_dout` = 16'h1234.
- Second tiles pulse, addr 18'h00020, while the first is still pending behind a long sprite transaction -> single read at 25'h0000080, `overrun` = 1 and stays 1.
- Sprite pulse coinciding with the sprite `mem_ack` -> data delivered and a new sprite read issued; no request lost.
- `reset` asserted while BUSY -> next cycle `mem_req` = 0, `sdram_dtack` = 1, all outputs at reset values; a late `mem_ack` after reset changes nothing.
